// File: rtl/max7219_pkg.sv
// Shared constants for the MAX7219 frame receiver: register map,
// frame width and receiver state encoding.
package max7219_pkg;

    localparam logic [3:0] ADDR_NOOP      = 4'h0;
    localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
    localparam logic [3:0] ADDR_DIGIT1    = 4'h2;
    localparam logic [3:0] ADDR_DIGIT2    = 4'h3;
    localparam logic [3:0] ADDR_DIGIT3    = 4'h4;
    localparam logic [3:0] ADDR_DIGIT4    = 4'h5;
    localparam logic [3:0] ADDR_DIGIT5    = 4'h6;
    localparam logic [3:0] ADDR_DIGIT6    = 4'h7;
    localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
    localparam logic [3:0] ADDR_DECODE    = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY = 4'hA;
    localparam logic [3:0] ADDR_SCANLIM   = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
    localparam logic [3:0] ADDR_TEST      = 4'hF;

    localparam logic [4:0] FRAME_BITS = 5'd16;

    typedef enum logic {
        IDLE,
        RECV
    } rx_state_e;

endpackage

// File: rtl/max7219_spi_receiver_sync_edge.sv
// Two-flop synchronizer with registered rise/fall strobes.
// The chain keeps tracking its input during reset so no false edge follows release.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;
    logic rise_q;
    logic fall_q;

    always_ff @(posedge clk) begin
        s1_q <= d_i;
        s2_q <= s1_q;
        s3_q <= s2_q;
        if (reset) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= s2_q & ~s3_q;
            fall_q <= ~s2_q & s3_q;
        end
    end

    assign sync_o = s2_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/max7219_spi_receiver.sv
// MAX7219 SPI slave: decodes 16-bit frames into the display register file.
// Define MAX7219_DOUT_EN to drive the daisy-chain output dout_o.
module max7219_spi_receiver
    import max7219_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk_i,
    input  logic       mosi_i,
    input  logic       cs_i,
    input  logic [2:0] rd_row_i,
    output logic [7:0] rd_data_o,
    output logic       display_on_o,
    output logic [3:0] intensity_o,
    output logic [2:0] scan_limit_o,
    output logic [7:0] decode_mode_o,
    output logic       display_test_o,
    output logic       frame_valid_o,
    output logic [3:0] frame_addr_o,
    output logic [7:0] frame_data_o,
    output logic       frame_err_o,
    output logic       dout_o
);

    logic sclk_rise;
    logic cs_rise;
    logic cs_fall;
    logic unused_sclk_sync;
    logic unused_sclk_fall;
    logic unused_cs_sync;

    sync_edge u_sclk_sync (
        .clk    (clk),
        .reset  (reset),
        .d_i    (sclk_i),
        .sync_o (unused_sclk_sync),
        .rise_o (sclk_rise),
        .fall_o (unused_sclk_fall)
    );

    sync_edge u_cs_sync (
        .clk    (clk),
        .reset  (reset),
        .d_i    (cs_i),
        .sync_o (unused_cs_sync),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    // mosi is only sampled on the delayed sclk strobe, so no edge detect
    logic mosi_s1_q;
    logic mosi_s2_q;

    always_ff @(posedge clk) begin
        mosi_s1_q <= mosi_i;
        mosi_s2_q <= mosi_s1_q;
    end

    rx_state_e   state_q;
    logic [4:0]  cnt_q;
    logic [15:0] shift_q;
    logic [7:0]  digit_q [8];
    logic [7:0]  decode_q;
    logic [3:0]  intensity_q;
    logic [2:0]  scan_limit_q;
    logic        display_on_q;
    logic        display_test_q;
    logic        frame_valid_q;
    logic        frame_err_q;
    logic [3:0]  frame_addr_q;
    logic [7:0]  frame_data_q;
    logic [7:0]  rd_data_q;
    logic [7:0]  rd_data_d;
    logic [3:0]  cmt_addr;
    logic [7:0]  cmt_data;
    logic [2:0]  cmt_digit;

    assign cmt_addr  = shift_q[11:8];
    assign cmt_data  = shift_q[7:0];
    assign cmt_digit = shift_q[10:8] - 3'd1;

`ifdef MAX7219_DOUT_EN
    logic dout_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            shift_q        <= '0;
            for (int i = 0; i < 8; i++) digit_q[i] <= '0;
            decode_q       <= '0;
            intensity_q    <= '0;
            scan_limit_q   <= '0;
            display_on_q   <= 1'b0;
            display_test_q <= 1'b0;
            frame_valid_q  <= 1'b0;
            frame_err_q    <= 1'b0;
            frame_addr_q   <= '0;
            frame_data_q   <= '0;
`ifdef MAX7219_DOUT_EN
            dout_q         <= 1'b0;
`endif
        end else begin
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (cs_fall) begin
                        state_q <= RECV;
                        shift_q <= '0;
`ifdef MAX7219_DOUT_EN
                        dout_q  <= 1'b0;
`endif
                    end
                end
                RECV: begin
                    if (cs_rise) begin
                        state_q <= IDLE;
                        if (cnt_q >= FRAME_BITS) begin
                            frame_valid_q <= 1'b1;
                            frame_addr_q  <= cmt_addr;
                            frame_data_q  <= cmt_data;
                            case (cmt_addr)
                                ADDR_NOOP: ;
                                ADDR_DECODE:    decode_q       <= cmt_data;
                                ADDR_INTENSITY: intensity_q    <= cmt_data[3:0];
                                ADDR_SCANLIM:   scan_limit_q   <= cmt_data[2:0];
                                ADDR_SHUTDOWN:  display_on_q   <= cmt_data[0];
                                ADDR_TEST:      display_test_q <= cmt_data[0];
                                default: begin
                                    if (cmt_addr >= ADDR_DIGIT0 &&
                                        cmt_addr <= ADDR_DIGIT7)
                                        digit_q[cmt_digit] <= cmt_data;
                                end
                            endcase
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end else if (sclk_rise) begin
                        shift_q <= {shift_q[14:0], mosi_s2_q};
                        if (cnt_q != 5'd31) cnt_q <= cnt_q + 5'd1;
`ifdef MAX7219_DOUT_EN
                        dout_q  <= shift_q[15];
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        rd_data_d = digit_q[rd_row_i];
        if (display_test_q)
            rd_data_d = 8'hFF;
        else if (!display_on_q)
            rd_data_d = 8'h00;
        else if (rd_row_i > scan_limit_q)
            rd_data_d = 8'h00;
    end

    always_ff @(posedge clk) begin
        if (reset) rd_data_q <= '0;
        else       rd_data_q <= rd_data_d;
    end

`ifdef MAX7219_DOUT_EN
    assign dout_o = dout_q;
`else
    logic unused_msb;
    assign unused_msb = shift_q[15];
    assign dout_o     = 1'b0;
`endif

    assign rd_data_o      = rd_data_q;
    assign display_on_o   = display_on_q;
    assign intensity_o    = intensity_q;
    assign scan_limit_o   = scan_limit_q;
    assign decode_mode_o  = decode_q;
    assign display_test_o = display_test_q;
    assign frame_valid_o  = frame_valid_q;
    assign frame_addr_o   = frame_addr_q;
    assign frame_data_o   = frame_data_q;
    assign frame_err_o    = frame_err_q;

endmodule

// File: tb/tb_max7219_spi_receiver.sv
// Directed bench for max7219_spi_receiver: frames, short/long bursts,
// display gating and reset in the middle of a frame.
module tb_max7219_spi_receiver;

    logic       clk = 1'b0;
    logic       reset;
    logic       sclk;
    logic       mosi;
    logic       cs;
    logic [2:0] rd_row;
    logic [7:0] rd_data;
    logic       display_on;
    logic [3:0] intensity;
    logic [2:0] scan_limit;
    logic [7:0] decode_mode;
    logic       display_test;
    logic       frame_valid;
    logic [3:0] frame_addr;
    logic [7:0] frame_data;
    logic       frame_err;
    logic       dout;

    int vectors = 0;
    int miscompares = 0;
    int vcnt = 0;
    int ecnt = 0;

    always #5 clk = ~clk;

    max7219_spi_receiver dut (
        .clk            (clk),
        .reset          (reset),
        .sclk_i         (sclk),
        .mosi_i         (mosi),
        .cs_i           (cs),
        .rd_row_i       (rd_row),
        .rd_data_o      (rd_data),
        .display_on_o   (display_on),
        .intensity_o    (intensity),
        .scan_limit_o   (scan_limit),
        .decode_mode_o  (decode_mode),
        .display_test_o (display_test),
        .frame_valid_o  (frame_valid),
        .frame_addr_o   (frame_addr),
        .frame_data_o   (frame_data),
        .frame_err_o    (frame_err),
        .dout_o         (dout)
    );

    always @(negedge clk) begin
        if (frame_valid === 1'b1) vcnt++;
        if (frame_err === 1'b1) ecnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clock_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = v[i];
            wait_clk(5);
            sclk = 1'b1;
            wait_clk(5);
            sclk = 1'b0;
        end
    endtask

    task automatic send(input logic [31:0] v, input int n);
        cs = 1'b0;
        wait_clk(5);
        clock_bits(v, n);
        wait_clk(5);
        cs = 1'b1;
        wait_clk(8);
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic read_row(input logic [2:0] r);
        rd_row = r;
        wait_clk(1);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        cs = 1'b1; sclk = 1'b0; mosi = 1'b0; rd_row = 3'd0;
        wait_clk(6);
        reset = 1'b0;
        wait_clk(6);
        vectors++;
        if ({rd_data, display_on, intensity, scan_limit, decode_mode,
             display_test, frame_addr, frame_data, dout} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %0h expected 0",
                     {rd_data, display_on, intensity, scan_limit, decode_mode,
                      display_test, frame_addr, frame_data, dout});
        end
        vectors++;
        if (vcnt !== 0 || ecnt !== 0) begin
            miscompares++;
            $display("FAIL reset_pulses: got v=%0d e=%0d expected 0 0",
                     vcnt, ecnt);
        end
    endtask

    task automatic test_shutdown;
        int v0 = vcnt;
        int e0 = ecnt;
        send(32'h0C01, 16);
        vectors++;
        if (vcnt - v0 !== 1 || ecnt - e0 !== 0) begin
            miscompares++;
            $display("FAIL shutdown_pulse: got v=%0d e=%0d expected 1 0",
                     vcnt - v0, ecnt - e0);
        end
        vectors++;
        if (frame_addr !== 4'hC || frame_data !== 8'h01) begin
            miscompares++;
            $display("FAIL shutdown_frame: got %0h/%0h expected c/01",
                     frame_addr, frame_data);
        end
        vectors++;
        if (display_on !== 1'b1) begin
            miscompares++;
            $display("FAIL shutdown_on: got %0b expected 1", display_on);
        end
        vectors++;
        if ({intensity, scan_limit, decode_mode, display_test, dout} !== '0)
        begin
            miscompares++;
            $display("FAIL shutdown_others: got %0h expected 0",
                     {intensity, scan_limit, decode_mode, display_test, dout});
        end
    endtask

    task automatic test_digit;
        send(32'h0B07, 16);
        send(32'h01FF, 16);
        read_row(3'd0);
        vectors++;
        if (rd_data !== 8'hFF) begin
            miscompares++;
            $display("FAIL digit_row0: got %0h expected ff", rd_data);
        end
        read_row(3'd1);
        vectors++;
        if (rd_data !== 8'h00) begin
            miscompares++;
            $display("FAIL digit_row1: got %0h expected 00", rd_data);
        end
    endtask

    task automatic test_scan_limit;
        send(32'h0B03, 16);
        send(32'h05AA, 16);
        vectors++;
        if (scan_limit !== 3'd3) begin
            miscompares++;
            $display("FAIL scanlim_reg: got %0d expected 3", scan_limit);
        end
        read_row(3'd4);
        vectors++;
        if (rd_data !== 8'h00) begin
            miscompares++;
            $display("FAIL scanlim_hidden: got %0h expected 00", rd_data);
        end
        read_row(3'd3);
        vectors++;
        if (rd_data !== 8'h00) begin
            miscompares++;
            $display("FAIL scanlim_edge: got %0h expected 00", rd_data);
        end
        send(32'h0B07, 16);
        read_row(3'd4);
        vectors++;
        if (rd_data !== 8'hAA) begin
            miscompares++;
            $display("FAIL scanlim_shown: got %0h expected aa", rd_data);
        end
    endtask

    task automatic test_short;
        int v0 = vcnt;
        int e0 = ecnt;
        send(32'h0C, 8);
        vectors++;
        if (ecnt - e0 !== 1 || vcnt - v0 !== 0) begin
            miscompares++;
            $display("FAIL short_pulse: got v=%0d e=%0d expected 0 1",
                     vcnt - v0, ecnt - e0);
        end
        vectors++;
        if (display_on !== 1'b1) begin
            miscompares++;
            $display("FAIL short_on: got %0b expected 1", display_on);
        end
        v0 = vcnt;
        e0 = ecnt;
        send(32'h0, 0);
        vectors++;
        if (ecnt - e0 !== 1 || vcnt - v0 !== 0) begin
            miscompares++;
            $display("FAIL glitch_pulse: got v=%0d e=%0d expected 0 1",
                     vcnt - v0, ecnt - e0);
        end
    endtask

    task automatic test_long;
        int v0 = vcnt;
        send(32'hF0A55, 20);
        vectors++;
        if (vcnt - v0 !== 1) begin
            miscompares++;
            $display("FAIL long_pulse: got %0d expected 1", vcnt - v0);
        end
        vectors++;
        if (intensity !== 4'h5 || frame_addr !== 4'hA ||
            frame_data !== 8'h55) begin
            miscompares++;
            $display("FAIL long_frame: got %0h/%0h/%0h expected 5/a/55",
                     intensity, frame_addr, frame_data);
        end
    endtask

    task automatic test_gating;
        send(32'h0C00, 16);
        read_row(3'd0);
        vectors++;
        if (rd_data !== 8'h00) begin
            miscompares++;
            $display("FAIL gate_off: got %0h expected 00", rd_data);
        end
        send(32'h0901, 16);
        vectors++;
        if (decode_mode !== 8'h01) begin
            miscompares++;
            $display("FAIL decode_reg: got %0h expected 01", decode_mode);
        end
        send(32'h0C01, 16);
        read_row(3'd0);
        vectors++;
        if (rd_data !== 8'hFF) begin
            miscompares++;
            $display("FAIL gate_on: got %0h expected ff", rd_data);
        end
    endtask

    task automatic test_reset_mid;
        int v0;
        int e0;
        cs = 1'b0;
        wait_clk(5);
        clock_bits(32'h0F01 >> 7, 9);
        reset = 1'b1;
        wait_clk(6);
        reset = 1'b0;
        wait_clk(3);
        v0 = vcnt;
        e0 = ecnt;
        cs = 1'b1;
        wait_clk(10);
        vectors++;
        if (vcnt - v0 !== 0 || ecnt - e0 !== 0) begin
            miscompares++;
            $display("FAIL midreset_pulse: got v=%0d e=%0d expected 0 0",
                     vcnt - v0, ecnt - e0);
        end
        vectors++;
        if (display_test !== 1'b0 || display_on !== 1'b0 ||
            intensity !== 4'h0) begin
            miscompares++;
            $display("FAIL midreset_regs: got %0b/%0b/%0h expected 0/0/0",
                     display_test, display_on, intensity);
        end
        send(32'h0F01, 16);
        for (int r = 0; r < 8; r++) begin
            read_row(r[2:0]);
            vectors++;
            if (rd_data !== 8'hFF) begin
                miscompares++;
                $display("FAIL test_row%0d: got %0h expected ff", r, rd_data);
            end
        end
    endtask

    initial begin
        test_reset;
        test_shutdown;
        test_digit;
        test_scan_limit;
        test_short;
        test_long;
        test_gating;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/max7219_spi_receiver.md
# max7219_spi_receiver

SPI slave that models the receiving end of the LED-matrix link: it samples the `sclk`/`mosi`/`cs` lines driven by the matrix driver and decodes the 16-bit MAX7219 frames. It holds the resulting register file: digits 0–7, decode mode, intensity, scan limit, shutdown and display test. It exposes the register file through a registered row-read port and per-frame status pulses. It sits on the FPGA side as a synthesizable display emulator and as the bus-level checker in driver benches.

## Interface
- No parameters.
- `clk` input 1 — system clock; `sclk`/`mosi`/`cs` are sampled on it.
- `reset` input 1 — synchronous, active-high.
- `sclk` input 1 — SPI clock from master, asynchronous to `clk`.
- `mosi` input 1 — serial data, MSB first.
- `cs` input 1 — chip select/LOAD, active-low; a rising edge latches the frame.
- `rd_row` input 3 — row index for the read port.
- `rd_data` output 8 — row pattern after display gating; 1-cycle latency.
- `display_on` output 1 — shutdown register bit0 (1 = normal operation).
- `intensity` output 4 — intensity register [3:0].
- `scan_limit` output 3 — scan-limit register [2:0].
- `decode_mode` output 8 — decode-mode register (stored only; no code-B decode).
- `display_test` output 1 — display-test register bit0.
- `frame_valid` output 1 — one-cycle pulse when a frame is committed.
- `frame_addr` output 4 — address of the last committed frame.
- `frame_data` output 8 — data of the last committed frame.
- `frame_err` output 1 — one-cycle pulse when a frame is dropped for being short.
- `dout` output 1 — daisy-chain output (see Configuration).

## Operation
- Each of `sclk`, `mosi` and `cs` passes through a 2-flop synchronizer; edge detect runs on the synchronized copies.
- Idle state (`cs`=1): the bit counter is held at 0.
- `cs` falling edge: enter RECV and clear the 16-bit shift register.
- RECV, each `sclk` rising edge: shift the synchronized `mosi` in at bit0, MSB first. The bit counter (5-bit) increments and saturates at 31.
- `cs` rising edge with count ≥ 16: commit `shift[11:8]` as the address and `shift[7:0]` as the data. Bits [15:12] are ignored. With more than 16 bits, the last 16 bits are used, matching the device.
- `cs` rising edge with count < 16: pulse `frame_err`, leave all registers unchanged, and return to IDLE.
- Commit address map:
  - 0x0: no-op.
  - 0x1–0x8: digit[addr-1].
  - 0x9: decode mode.
  - 0xA: intensity (data[3:0]).
  - 0xB: scan limit (data[2:0]).
  - 0xC: shutdown (data[0]).
  - 0xF: display test (data[0]).
  - 0xD, 0xE: ignored, but `frame_valid` still pulses.
- `rd_data` priority:
  1. `display_test`=1 → 0xFF.
  2. `display_on`=0 → 0x00.
  3. `rd_row` > `scan_limit` → 0x00.
  4. Otherwise digit[`rd_row`].
- `cs` glitch: a `cs` low period with zero `sclk` edges is a short frame → `frame_err`.
- Reset mid-frame: abort the frame, return to IDLE, and reload all reset values. The next `cs` rising edge produces no pulse until a fresh falling edge has occurred.

## Timing
- Synchronizer plus edge detect gives 3 `clk` cycles from pin edge to internal edge strobe.
- `sclk` high and low phases must each be ≥ 4 `clk` periods. Faster `sclk` is unsupported and unchecked.
- `mosi` must be stable ≥ 4 `clk` periods before the `sclk` rising edge.
- Frame commit: registers, `frame_addr`/`frame_data` and the `frame_valid` pulse all update on the cycle after the internal `cs` rising strobe (4 cycles after the pin edge). `frame_err` has the same latency.
- `frame_valid` and `frame_err` are mutually exclusive and last exactly 1 cycle.
- `rd_data` is registered: a `rd_row` value applied at cycle N appears at N+1. A register change is visible on `rd_data` 1 cycle after commit.
- Reset values:
  - All digits 0x00.
  - `decode_mode` 0x00, `intensity` 0x0, `scan_limit` 0, `display_on` 0, `display_test` 0.
  - `rd_data` 0x00, `frame_addr` 0x0, `frame_data` 0x00.
  - `frame_valid` 0, `frame_err` 0, `dout` 0.

## Configuration
- `MAX7219_DOUT_EN` defined: `dout` presents the bit shifted out of shift-register bit15 on each internal `sclk` rising strobe. It is held while `cs`=0 and is cleared to 0 on the `cs` falling strobe. This lets a second receiver be chained behind the first.
- `MAX7219_DOUT_EN` undefined: `dout` is tied to 0 and no extra logic is generated.

## Structure
- Package `max7219_pkg` holds:
  - Register address constants: `ADDR_NOOP`, `ADDR_DIGIT0`…`ADDR_DIGIT7`, `ADDR_DECODE`, `ADDR_INTENSITY`, `ADDR_SCANLIM`, `ADDR_SHUTDOWN`, `ADDR_TEST`.
  - Frame width constant `FRAME_BITS`=16.
  - Receiver state encoding: IDLE, RECV.
- One sub-module, `sync_edge`: 2-flop synchronizer with registered rise/fall strobes. It is instantiated for `sclk` and `cs`; `mosi` uses only its synchronized output.

## Test plan
- Reset, then frame 0x0C01 → one `frame_valid`, `frame_addr`=0xC, `frame_data`=0x01, `display_on`=1; all other outputs keep their reset values.
- After 0x0C01 and 0x0B07, send 0x01FF, then set `rd_row`=0 → `rd_data`=0xFF one cycle later; `rd_row`=1 → 0x00.
- Send 0x0B03 then 0x05AA, then `rd_row`=4 → `rd_data`=0x00 (beyond scan limit); 0x0B07, then `rd_row`=4 → 0xAA.
- 8-bit burst 0x0C inside one `cs` low → `frame_err` pulse, no `frame_valid`, `display_on` unchanged.
- 20-bit burst 0xF0A55 → last 16 bits 0x0A55 committed: `intensity`=0x5, `frame_addr`=0xA.
- Assert `reset` after 9 bits of 0x0F01, release it, then raise `cs` → no pulses, `display_test`=0; a following complete 0x0F01 → `rd_data`=0xFF for every `rd_row`.
